chirp_sequencer: RTL and testbench

Sequencer that drives the chirp generator's configuration inputs from a small profile table. It steps through profiles 0..last_idx, playing each for a programmed number of sweeps, and optionally loops. Completion is detected by watching the generator's nco_ctrl against the active profile's end frequency. It sits between the host register interface and the chirp generator, and owns that generator's reset.

---
 rtl/mawg_chirp_pkg.sv | 25 ++
 rtl/chirp_profile_ram.sv | 54 +++++
 rtl/chirp_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_chirp_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mawg_chirp_pkg.sv
// Shared constants for the chirp sequencer: profile field codes, mode-word layout
// and FSM state encoding.
package mawg_chirp_pkg;

   localparam int unsigned NumFields = 5;

   localparam logic [2:0] FLD_MIN  = 3'd0;
   localparam logic [2:0] FLD_MAX  = 3'd1;
   localparam logic [2:0] FLD_INC  = 3'd2;
   localparam logic [2:0] FLD_DIV  = 3'd3;
   localparam logic [2:0] FLD_MODE = 3'd4;

   localparam int unsigned MODE_DELAY_LSB = 0;
   localparam int unsigned MODE_DELAY_W   = 4;
   localparam int unsigned MODE_DOWN_BIT  = 4;
   localparam int unsigned MODE_REP_LSB   = 8;
   localparam int unsigned MODE_REP_W     = 8;

   typedef logic [1:0] state_t;

   localparam state_t StIdle = 2'd0;
   localparam state_t StLoad = 2'd1;
   localparam state_t StRun  = 2'd2;

endpackage

// File: rtl/chirp_profile_ram.sv
// Profile table: DEPTH entries of five 32-bit words, one write port and an
// asynchronous read of a whole entry.
module chirp_profile_ram
   import mawg_chirp_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [2:0]    wfield,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rd_min,
   output logic [31:0]   rd_max,
   output logic [31:0]   rd_inc,
   output logic [31:0]   rd_div,
   output logic [31:0]   rd_mode
);

   logic [NumFields-1:0][31:0] mem_q [DEPTH];
   logic [NumFields-1:0][31:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         case (wfield)
            FLD_MIN:  mem_d[waddr][0] = wdata;
            FLD_MAX:  mem_d[waddr][1] = wdata;
            FLD_INC:  mem_d[waddr][2] = wdata;
            FLD_DIV:  mem_d[waddr][3] = wdata;
            FLD_MODE: mem_d[waddr][4] = wdata;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_min  = mem_q[raddr][0];
   assign rd_max  = mem_q[raddr][1];
   assign rd_inc  = mem_q[raddr][2];
   assign rd_div  = mem_q[raddr][3];
   assign rd_mode = mem_q[raddr][4];

endmodule

// File: rtl/chirp_sequencer.sv
// Steps the chirp generator through a table of profiles, counting sweeps by watching
// nco_ctrl cross the active end frequency, and owns the generator's reset.
module chirp_sequencer
   import mawg_chirp_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [2:0]    cfg_field,
   input  logic [31:0]   cfg_data,
   input  logic          start,
   input  logic          stop,
   input  logic          loop_en,
   input  logic [AW-1:0] last_idx,
   input  logic [31:0]   nco_ctrl,
   output logic [31:0]   min_ctrl,
   output logic [31:0]   max_ctrl,
   output logic [31:0]   inc_rate,
   output logic [31:0]   div_rate,
   output logic [3:0]    delay,
   output logic          is_down,
   output logic          chirp_rst,
   output logic          busy,
   output logic [AW-1:0] profile_idx,
   output logic          seq_done
);

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW-1:0] last_idx_q, last_idx_d;
   logic [31:0]   min_ctrl_q, min_ctrl_d;
   logic [31:0]   max_ctrl_q, max_ctrl_d;
   logic [31:0]   inc_rate_q, inc_rate_d;
   logic [31:0]   div_rate_q, div_rate_d;
   logic [3:0]    delay_q, delay_d;
   logic          is_down_q, is_down_d;
   logic [7:0]    repeat_q, repeat_d;
   logic          arm_q, arm_d;
   logic [7:0]    sweep_cnt_q, sweep_cnt_d;
   logic          end_hit_q;
   logic          seq_done_q, seq_done_d;

   logic          load;
   logic          end_hit;
   logic          end_evt;
   logic [7:0]    rep_eff;
   logic [7:0]    cnt_inc;
   logic [31:0]   rd_min, rd_max, rd_inc, rd_div, rd_mode;
   logic          unused_mode_bits;

   // Read port follows the next index so a LOAD entry captures the new profile.
   chirp_profile_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (cfg_we),
      .waddr   (cfg_addr),
      .wfield  (cfg_field),
      .wdata   (cfg_data),
      .raddr   (idx_d),
      .rd_min  (rd_min),
      .rd_max  (rd_max),
      .rd_inc  (rd_inc),
      .rd_div  (rd_div),
      .rd_mode (rd_mode)
   );

   assign unused_mode_bits = ^{rd_mode[31:16], rd_mode[7:5]};

   assign end_hit = is_down_q ? (nco_ctrl <= min_ctrl_q) : (nco_ctrl >= max_ctrl_q);
   assign end_evt = (state_q == StRun) && end_hit && !end_hit_q;
   assign rep_eff = (repeat_q == 8'd0) ? 8'd1 : repeat_q;
   assign cnt_inc = sweep_cnt_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      last_idx_d  = last_idx_q;
      arm_d       = arm_q;
      sweep_cnt_d = sweep_cnt_q;
      seq_done_d  = 1'b0;
      load        = 1'b0;
      case (state_q)
         StIdle: begin
            if (start && !stop) begin
               idx_d      = '0;
               last_idx_d = last_idx;
               load       = 1'b1;
            end
         end
         StLoad: begin
            state_d = stop ? StIdle : StRun;
         end
         StRun: begin
            if (stop) begin
               state_d = StIdle;
            end else if (end_evt) begin
               // The first crossing is the generator's post-reset ramp from 0.
               if (!arm_q) begin
                  arm_d = 1'b1;
               end else if (cnt_inc == rep_eff) begin
                  if (idx_q < last_idx_q) begin
                     idx_d = idx_q + 1'b1;
                     load  = 1'b1;
                  end else if (loop_en) begin
                     idx_d = '0;
                     load  = 1'b1;
                  end else begin
                     state_d    = StIdle;
                     seq_done_d = 1'b1;
                  end
               end else begin
                  sweep_cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (load) begin
         state_d     = StLoad;
         arm_d       = 1'b0;
         sweep_cnt_d = '0;
      end
   end

   always_comb begin
      min_ctrl_d = min_ctrl_q;
      max_ctrl_d = max_ctrl_q;
      inc_rate_d = inc_rate_q;
      div_rate_d = div_rate_q;
      delay_d    = delay_q;
      is_down_d  = is_down_q;
      repeat_d   = repeat_q;
      if (load) begin
         min_ctrl_d = rd_min;
         max_ctrl_d = rd_max;
         inc_rate_d = rd_inc;
         div_rate_d = rd_div;
         delay_d    = rd_mode[MODE_DELAY_LSB +: MODE_DELAY_W];
         is_down_d  = rd_mode[MODE_DOWN_BIT];
         repeat_d   = rd_mode[MODE_REP_LSB +: MODE_REP_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         last_idx_q  <= '0;
         min_ctrl_q  <= '0;
         max_ctrl_q  <= '0;
         inc_rate_q  <= '0;
         div_rate_q  <= '0;
         delay_q     <= '0;
         is_down_q   <= 1'b0;
         repeat_q    <= '0;
         arm_q       <= 1'b0;
         sweep_cnt_q <= '0;
         end_hit_q   <= 1'b0;
         seq_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         last_idx_q  <= last_idx_d;
         min_ctrl_q  <= min_ctrl_d;
         max_ctrl_q  <= max_ctrl_d;
         inc_rate_q  <= inc_rate_d;
         div_rate_q  <= div_rate_d;
         delay_q     <= delay_d;
         is_down_q   <= is_down_d;
         repeat_q    <= repeat_d;
         arm_q       <= arm_d;
         sweep_cnt_q <= sweep_cnt_d;
         end_hit_q   <= end_hit;
         seq_done_q  <= seq_done_d;
      end
   end

   assign min_ctrl    = min_ctrl_q;
   assign max_ctrl    = max_ctrl_q;
   assign inc_rate    = inc_rate_q;
   assign div_rate    = div_rate_q;
   assign delay       = delay_q;
   assign is_down     = is_down_q;
   assign chirp_rst   = (state_q != StRun);
   assign busy        = (state_q != StIdle);
   assign profile_idx = idx_q;
   assign seq_done    = seq_done_q;

endmodule

// File: tb/tb_chirp_sequencer.sv
// Directed bench for chirp_sequencer: inputs change and outputs are sampled on the
// falling edge; nco_ctrl is driven directly to create end-frequency crossings.
module tb_chirp_sequencer;
   import mawg_chirp_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [2:0]    cfg_field;
   logic [31:0]   cfg_data;
   logic          start;
   logic          stop;
   logic          loop_en;
   logic [AW-1:0] last_idx;
   logic [31:0]   nco_ctrl;
   logic [31:0]   min_ctrl, max_ctrl, inc_rate, div_rate;
   logic [3:0]    delay;
   logic          is_down;
   logic          chirp_rst;
   logic          busy;
   logic [AW-1:0] profile_idx;
   logic          seq_done;

   int checks = 0;
   int errors = 0;

   chirp_sequencer #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_field   (cfg_field),
      .cfg_data    (cfg_data),
      .start       (start),
      .stop        (stop),
      .loop_en     (loop_en),
      .last_idx    (last_idx),
      .nco_ctrl    (nco_ctrl),
      .min_ctrl    (min_ctrl),
      .max_ctrl    (max_ctrl),
      .inc_rate    (inc_rate),
      .div_rate    (div_rate),
      .delay       (delay),
      .is_down     (is_down),
      .chirp_rst   (chirp_rst),
      .busy        (busy),
      .profile_idx (profile_idx),
      .seq_done    (seq_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [2:0] f, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_field = f; cfg_data = d;
      step();
      cfg_we = 1'b0;
   endtask

   // One crossing: a non-hitting cycle, then one hitting cycle (the decision edge).
   task automatic pulse_end(input logic [31:0] idle_v, input logic [31:0] hit_v);
      nco_ctrl = idle_v;
      step();
      nco_ctrl = hit_v;
      step();
      nco_ctrl = idle_v;
   endtask

   task automatic begin_seq(input logic [AW-1:0] li, input logic lp);
      last_idx = li; loop_en = lp; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      checks++;
      if ({busy, chirp_rst, seq_done, profile_idx} !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL reset_status: got %b want 01000", {busy, chirp_rst, seq_done, profile_idx});
      end
      checks++;
      if ({min_ctrl, max_ctrl, inc_rate, div_rate, delay, is_down} !== '0) begin
         errors++;
         $display("FAIL reset_cfg: got min %0d max %0d inc %0d div %0d dly %0d dn %b want all 0",
                  min_ctrl, max_ctrl, inc_rate, div_rate, delay, is_down);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_profile();
      wr(2'd0, FLD_MIN, 32'd100);
      wr(2'd0, FLD_MAX, 32'd1000);
      wr(2'd0, FLD_INC, 32'd100);
      wr(2'd0, FLD_DIV, 32'd0);
      wr(2'd0, FLD_MODE, 32'h0000_0300);
      begin_seq(2'd0, 1'b0);
      checks++;
      if ({busy, chirp_rst} !== 2'b11 || min_ctrl !== 32'd100 || max_ctrl !== 32'd1000 ||
          inc_rate !== 32'd100) begin
         errors++;
         $display("FAIL single_load: got busy %b rst %b min %0d max %0d inc %0d want 1 1 100 1000 100",
                  busy, chirp_rst, min_ctrl, max_ctrl, inc_rate);
      end
      step();
      checks++;
      if ({busy, chirp_rst} !== 2'b10) begin
         errors++;
         $display("FAIL single_run: got busy/chirp_rst %b want 10", {busy, chirp_rst});
      end
      for (int i = 0; i < 3; i++) pulse_end(32'd0, 32'd1000);
      checks++;
      if ({busy, seq_done} !== 2'b10) begin
         errors++;
         $display("FAIL single_arm: got busy/seq_done %b want 10 after arm+2 sweeps", {busy, seq_done});
      end
      pulse_end(32'd0, 32'd1000);
      checks++;
      if ({busy, chirp_rst, seq_done} !== 3'b011) begin
         errors++;
         $display("FAIL single_done: got busy/chirp_rst/seq_done %b want 011", {busy, chirp_rst, seq_done});
      end
      step();
      checks++;
      if (seq_done !== 1'b0) begin
         errors++;
         $display("FAIL single_done_pulse: got seq_done %b want 0", seq_done);
      end
   endtask

   task automatic test_stop();
      wr(2'd0, FLD_MODE, 32'h0000_0400);
      begin_seq(2'd0, 1'b0);
      step();
      pulse_end(32'd0, 32'd1000);
      pulse_end(32'd0, 32'd1000);
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++;
      if ({busy, chirp_rst, seq_done} !== 3'b010 || max_ctrl !== 32'd1000) begin
         errors++;
         $display("FAIL stop_run: got busy/rst/done %b max %0d want 010 1000",
                  {busy, chirp_rst, seq_done}, max_ctrl);
      end
      begin_seq(2'd0, 1'b0);
      checks++;
      if ({busy, chirp_rst, profile_idx} !== {1'b1, 1'b1, 2'd0}) begin
         errors++;
         $display("FAIL stop_restart: got busy/rst/idx %b want 1100", {busy, chirp_rst, profile_idx});
      end
      step();
      for (int i = 0; i < 4; i++) pulse_end(32'd0, 32'd1000);
      checks++;
      if ({busy, seq_done} !== 2'b10) begin
         errors++;
         $display("FAIL stop_cnt_cleared: got busy/seq_done %b want 10 after 3 sweeps", {busy, seq_done});
      end
      pulse_end(32'd0, 32'd1000);
      checks++;
      if ({busy, seq_done} !== 2'b01) begin
         errors++;
         $display("FAIL stop_restart_done: got busy/seq_done %b want 01", {busy, seq_done});
      end
      step();
   endtask

   task automatic test_start_stop();
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      checks++;
      if ({busy, chirp_rst} !== 2'b01) begin
         errors++;
         $display("FAIL start_stop: got busy/chirp_rst %b want 01", {busy, chirp_rst});
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL start_stop_idle: got busy %b want 0", busy);
      end
   endtask

   task automatic test_loop_and_write();
      wr(2'd0, FLD_MODE, 32'h0000_0200);
      wr(2'd1, FLD_MIN, 32'd50);
      wr(2'd1, FLD_MAX, 32'd500);
      wr(2'd1, FLD_INC, 32'd7);
      wr(2'd1, FLD_DIV, 32'd1);
      wr(2'd1, FLD_MODE, 32'h0000_0115);
      begin_seq(2'd1, 1'b1);
      checks++;
      if (profile_idx !== 2'd0 || chirp_rst !== 1'b1 || max_ctrl !== 32'd1000 || is_down !== 1'b0) begin
         errors++;
         $display("FAIL loop_load0: got idx %0d rst %b max %0d dn %b want 0 1 1000 0",
                  profile_idx, chirp_rst, max_ctrl, is_down);
      end
      step();
      for (int i = 0; i < 3; i++) pulse_end(32'd0, 32'd1000);
      checks++;
      if (profile_idx !== 2'd1 || {busy, chirp_rst} !== 2'b11 || min_ctrl !== 32'd50 ||
          max_ctrl !== 32'd500 || inc_rate !== 32'd7 || div_rate !== 32'd1 ||
          delay !== 4'd5 || is_down !== 1'b1) begin
         errors++;
         $display("FAIL loop_load1: got idx %0d busy %b rst %b min %0d max %0d inc %0d div %0d dly %0d dn %b want 1 1 1 50 500 7 1 5 1",
                  profile_idx, busy, chirp_rst, min_ctrl, max_ctrl, inc_rate, div_rate, delay, is_down);
      end
      step();
      checks++;
      if (chirp_rst !== 1'b0) begin
         errors++;
         $display("FAIL loop_one_rst_cycle: got chirp_rst %b want 0", chirp_rst);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (profile_idx !== 2'd1 || chirp_rst !== 1'b0) begin
         errors++;
         $display("FAIL start_while_busy: got idx %0d rst %b want 1 0", profile_idx, chirp_rst);
      end
      pulse_end(32'd600, 32'd10);
      pulse_end(32'd600, 32'd10);
      checks++;
      if (profile_idx !== 2'd0 || chirp_rst !== 1'b1 || max_ctrl !== 32'd1000 || is_down !== 1'b0) begin
         errors++;
         $display("FAIL loop_wrap: got idx %0d rst %b max %0d dn %b want 0 1 1000 0",
                  profile_idx, chirp_rst, max_ctrl, is_down);
      end
      step();
      wr(2'd0, FLD_MAX, 32'd2000);
      checks++;
      if (max_ctrl !== 32'd1000) begin
         errors++;
         $display("FAIL write_isolated: got max %0d want 1000", max_ctrl);
      end
      for (int i = 0; i < 3; i++) pulse_end(32'd0, 32'd1000);
      checks++;
      if (profile_idx !== 2'd1) begin
         errors++;
         $display("FAIL loop_second_pass: got idx %0d want 1", profile_idx);
      end
      step();
      pulse_end(32'd600, 32'd10);
      pulse_end(32'd600, 32'd10);
      checks++;
      if (profile_idx !== 2'd0 || max_ctrl !== 32'd2000) begin
         errors++;
         $display("FAIL write_applied: got idx %0d max %0d want 0 2000", profile_idx, max_ctrl);
      end
      loop_en = 1'b0;
      step();
      for (int i = 0; i < 3; i++) pulse_end(32'd0, 32'd2000);
      checks++;
      if (profile_idx !== 2'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL loop_off_advance: got idx %0d busy %b want 1 1", profile_idx, busy);
      end
      step();
      pulse_end(32'd600, 32'd10);
      pulse_end(32'd600, 32'd10);
      checks++;
      if ({busy, seq_done} !== 2'b01) begin
         errors++;
         $display("FAIL loop_off_done: got busy/seq_done %b want 01", {busy, seq_done});
      end
      step();
   endtask

   task automatic test_repeat_zero();
      wr(2'd0, FLD_MODE, 32'h0000_0000);
      begin_seq(2'd0, 1'b0);
      step();
      nco_ctrl = 32'd0;
      pulse_end(32'd0, 32'd2000);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rep0_arm: got busy %b want 1", busy);
      end
      pulse_end(32'd0, 32'd2000);
      checks++;
      if ({busy, seq_done} !== 2'b01) begin
         errors++;
         $display("FAIL rep0_done: got busy/seq_done %b want 01", {busy, seq_done});
      end
      step();
   endtask

   task automatic test_reset_mid_run();
      begin_seq(2'd0, 1'b0);
      step();
      checks++;
      if (chirp_rst !== 1'b0 || max_ctrl !== 32'd2000) begin
         errors++;
         $display("FAIL rst_pre_run: got rst %b max %0d want 0 2000", chirp_rst, max_ctrl);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({busy, chirp_rst, seq_done, profile_idx} !== {1'b0, 1'b1, 1'b0, 2'd0} ||
          {min_ctrl, max_ctrl, inc_rate, div_rate, delay, is_down} !== '0) begin
         errors++;
         $display("FAIL rst_mid_run: got busy %b rst %b done %b idx %0d min %0d max %0d inc %0d want 0 1 0 0 0 0 0",
                  busy, chirp_rst, seq_done, profile_idx, min_ctrl, max_ctrl, inc_rate);
      end
      begin_seq(2'd0, 1'b0);
      checks++;
      if (busy !== 1'b1 || min_ctrl !== 32'd0 || max_ctrl !== 32'd0 || inc_rate !== 32'd0) begin
         errors++;
         $display("FAIL rst_storage: got busy %b min %0d max %0d inc %0d want 1 0 0 0",
                  busy, min_ctrl, max_ctrl, inc_rate);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_field = '0; cfg_data = '0;
      start = 1'b0; stop = 1'b0; loop_en = 1'b0; last_idx = '0; nco_ctrl = '0;
      test_reset();
      test_single_profile();
      test_stop();
      test_start_stop();
      test_loop_and_write();
      test_repeat_zero();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
